// File: rtl/mmss_bcd_decoder_pkg.sv
// Shared definitions for the minute/second binary-to-BCD decoder:
// field width, legal range, FSM state encoding and the BCD digit type.
package mmss_bcd_decoder_pkg;

  localparam int IN_W    = 6;
  localparam int MAX_VAL = 59;
  localparam int BCD_W   = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    DONE    = 2'd2
  } state_t;

  typedef logic [3:0] bcd_digit_t;

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // when doubled, so it is pre-biased by 3 before the shift.
  function automatic logic [3:0] add3_nibble(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/bin_to_bcd_field.sv
// One field of the decoder: holds the BCD/binary scratch pair and performs a
// single add-3/shift step per clock when asked. After IN_W steps the two BCD
// nibbles hold the tens and ones digits of the loaded value.
module bin_to_bcd_field #(
  parameter int IN_W = mmss_bcd_decoder_pkg::IN_W
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              load,
  input  logic                              step,
  input  logic [IN_W-1:0]                   bin_in,
  output mmss_bcd_decoder_pkg::bcd_digit_t  tens,
  output mmss_bcd_decoder_pkg::bcd_digit_t  ones
);

  localparam int BCD_W = mmss_bcd_decoder_pkg::BCD_W;

  logic [BCD_W-1:0]      bcd_q;
  logic [IN_W-1:0]       bin_q;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W+IN_W-1:0] shifted;

  // Correct both nibbles, then shift the whole scratch word left by one.
  always_comb begin
    bcd_adj = {mmss_bcd_decoder_pkg::add3_nibble(bcd_q[7:4]),
               mmss_bcd_decoder_pkg::add3_nibble(bcd_q[3:0])};
    shifted = {bcd_adj, bin_q} << 1;
  end

  // Scratch registers: cleared/loaded at conversion start, stepped while converting.
  always_ff @(posedge clk) begin
    if (reset) begin
      bcd_q <= '0;
      bin_q <= '0;
    end else if (load) begin
      bcd_q <= '0;
      bin_q <= bin_in;
    end else if (step) begin
      bcd_q <= shifted[BCD_W+IN_W-1:IN_W];
      bin_q <= shifted[IN_W-1:0];
    end
  end

  assign tens = bcd_q[7:4];
  assign ones = bcd_q[3:0];

endmodule

// File: rtl/mmss_bcd_decoder.sv
// Converts binary minute/second counter values into four BCD digits for the
// VGA digit renderer. Both fields run double dabble in parallel; results are
// published only on completion so the display never sees partial digits.
module mmss_bcd_decoder #(
  parameter int IN_W       = mmss_bcd_decoder_pkg::IN_W,
  parameter int MAX_VAL    = mmss_bcd_decoder_pkg::MAX_VAL,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [IN_W-1:0]                   min_in,
  input  logic [IN_W-1:0]                   sec_in,
  output logic                              busy,
  output logic                              valid,
  output mmss_bcd_decoder_pkg::bcd_digit_t  min_tens,
  output mmss_bcd_decoder_pkg::bcd_digit_t  min_ones,
  output mmss_bcd_decoder_pkg::bcd_digit_t  sec_tens,
  output mmss_bcd_decoder_pkg::bcd_digit_t  sec_ones,
  output logic                              overrange
);

  import mmss_bcd_decoder_pkg::*;

  localparam int              ITER_W   = (IN_W > 1) ? $clog2(IN_W) : 1;
  localparam logic [IN_W-1:0] MAX_BIN  = IN_W'(MAX_VAL);
  localparam logic [ITER_W-1:0] LAST_IT = ITER_W'(IN_W - 1);

  state_t            state;
  state_t            state_next;
  logic [ITER_W-1:0] iter;
  logic              pending;
  logic              overrange_latched;
  logic [IN_W-1:0]   last_min;
  logic [IN_W-1:0]   last_sec;
  logic [IN_W-1:0]   min_clamped;
  logic [IN_W-1:0]   sec_clamped;
  logic              input_changed;
  logic              request;
  logic              field_over;
  logic              load;
  logic              step;
  bcd_digit_t        scr_min_tens;
  bcd_digit_t        scr_min_ones;
  bcd_digit_t        scr_sec_tens;
  bcd_digit_t        scr_sec_ones;

  // Request qualification, clamping and out-of-range detection on the raw inputs.
  always_comb begin
    input_changed = AUTO_START && ((min_in != last_min) || (sec_in != last_sec));
    request       = start || pending || input_changed;
    field_over    = (min_in > MAX_BIN) || (sec_in > MAX_BIN);
    min_clamped   = (min_in > MAX_BIN) ? MAX_BIN : min_in;
    sec_clamped   = (sec_in > MAX_BIN) ? MAX_BIN : sec_in;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next-state logic: IDLE -> CONVERT for IN_W steps -> DONE -> IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (request)        state_next = CONVERT;
      CONVERT: if (iter == LAST_IT) state_next = DONE;
      DONE:                        state_next = IDLE;
      default:                     state_next = IDLE;
    endcase
  end

  // FSM outputs: field load/step strobes and the busy flag.
  always_comb begin
    load = (state == IDLE) && request;
    step = (state == CONVERT);
    busy = (state != IDLE);
  end

  // Control registers: iteration count, pending re-run flag, last-latched inputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter              <= '0;
      pending           <= 1'b0;
      last_min          <= '0;
      last_sec          <= '0;
      overrange_latched <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          pending <= 1'b0;
          if (request) begin
            iter              <= '0;
            last_min          <= min_in;
            last_sec          <= sec_in;
            overrange_latched <= field_over;
          end
        end
        CONVERT: begin
          iter <= iter + ITER_W'(1);
          if (input_changed) pending <= 1'b1;
        end
        default: begin
          if (input_changed) pending <= 1'b1;
        end
      endcase
    end
  end

  // Output registers: publish digits and overrange together with a one-cycle valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid     <= 1'b0;
      min_tens  <= '0;
      min_ones  <= '0;
      sec_tens  <= '0;
      sec_ones  <= '0;
      overrange <= 1'b0;
    end else begin
      valid <= (state == DONE);
      if (state == DONE) begin
        min_tens  <= scr_min_tens;
        min_ones  <= scr_min_ones;
        sec_tens  <= scr_sec_tens;
        sec_ones  <= scr_sec_ones;
        overrange <= overrange_latched;
      end
    end
  end

  bin_to_bcd_field #(.IN_W(IN_W)) u_min_field (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .bin_in (min_clamped),
    .tens   (scr_min_tens),
    .ones   (scr_min_ones)
  );

  bin_to_bcd_field #(.IN_W(IN_W)) u_sec_field (
    .clk    (clk),
    .reset  (reset),
    .load   (load),
    .step   (step),
    .bin_in (sec_clamped),
    .tens   (scr_sec_tens),
    .ones   (scr_sec_ones)
  );

endmodule

// File: tb/tb_mmss_bcd_decoder.sv
// Testbench for mmss_bcd_decoder: directed latency/handshake scenarios plus
// random and exhaustive value coverage, checked through an expected-result
// queue that a monitor drains on every valid pulse.
module tb_mmss_bcd_decoder;

  typedef struct {
    int mt;
    int mo;
    int st;
    int so;
    int ovr;
  } exp_t;

  logic       clk;
  logic       reset;
  logic       start;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       busy;
  logic       valid;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       overrange;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic prev_valid = 1'b0;

  mmss_bcd_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .min_in    (min_in),
    .sec_in    (sec_in),
    .busy      (busy),
    .valid     (valid),
    .min_tens  (min_tens),
    .min_ones  (min_ones),
    .sec_tens  (sec_tens),
    .sec_ones  (sec_ones),
    .overrange (overrange)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: clamp to 59, then split into decimal digits.
  function automatic exp_t model(input int m, input int s);
    exp_t e;
    int mc;
    int sc;
    mc    = (m > 59) ? 59 : m;
    sc    = (s > 59) ? 59 : s;
    e.mt  = mc / 10;
    e.mo  = mc % 10;
    e.st  = sc / 10;
    e.so  = sc % 10;
    e.ovr = ((m > 59) || (s > 59)) ? 1 : 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Issue one conversion and wait for its valid; reports latency and busy-high cycles.
  task automatic applyStimulus(input logic [5:0] m, input logic [5:0] s, input bit use_start,
                               output int lat, output int busy_cycles);
    @(negedge clk);
    min_in = m;
    sec_in = s;
    start  = use_start;
    sb.push_back(model(int'(m), int'(s)));
    @(negedge clk);
    start       = 1'b0;
    lat         = 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    while (valid !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
      if (valid !== 1'b1 && busy === 1'b1) busy_cycles++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL valid_timeout: got no valid after %0d cycles, expected valid", lat);
    end
  endtask

  // Monitor: compare every presented result against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid === 1'b1) begin
        checkOutput("valid_pulse_width", int'(prev_valid), 0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_valid: got valid=1, expected no result outstanding");
        end else begin
          e = sb.pop_front();
          checkOutput("min_tens", int'(min_tens), e.mt);
          checkOutput("min_ones", int'(min_ones), e.mo);
          checkOutput("sec_tens", int'(sec_tens), e.st);
          checkOutput("sec_ones", int'(sec_ones), e.so);
          checkOutput("overrange", int'(overrange), e.ovr);
        end
      end
      prev_valid = valid;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main stimulus sequence.
  initial begin
    int lat;
    int bc;
    int gap;
    int wait_cnt;
    logic [5:0] pm;
    logic [5:0] ps;
    logic [5:0] rm;
    logic [5:0] rs;
    bit us;

    reset  = 1'b1;
    start  = 1'b0;
    min_in = '0;
    sec_in = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_valid", int'(valid), 0);
    checkOutput("reset_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    checkOutput("reset_overrange", int'(overrange), 0);
    reset = 1'b0;

    // Zero conversion and its latency.
    applyStimulus(6'd0, 6'd0, 1'b1, lat, bc);
    checkOutput("t1_latency", lat, 7);

    // Largest legal values: busy for 7 cycles, drops as valid rises.
    applyStimulus(6'd59, 6'd59, 1'b1, lat, bc);
    checkOutput("t2_latency", lat, 7);
    checkOutput("t2_busy_cycles", bc, 7);
    checkOutput("t2_busy_at_valid", int'(busy), 0);

    // Over-range inputs clamp; then a normal value clears overrange.
    applyStimulus(6'd63, 6'd60, 1'b1, lat, bc);
    applyStimulus(6'd7, 6'd42, 1'b1, lat, bc);

    // Start during busy is ignored; an input change during busy reruns once.
    @(negedge clk);
    min_in = 6'd5;
    sec_in = 6'd10;
    start  = 1'b1;
    sb.push_back(model(5, 10));
    sb.push_back(model(5, 11));
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    start  = 1'b1;
    sec_in = 6'd11;
    @(negedge clk);
    start    = 1'b0;
    wait_cnt = 0;
    while (valid !== 1'b1 && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    checkOutput("t4_first_valid_seen", int'(valid), 1);
    gap = 0;
    do begin
      @(negedge clk);
      gap++;
    end while (valid !== 1'b1 && gap < 20);
    checkOutput("t4_gap", gap, 8);
    repeat (12) @(negedge clk);

    // Reset mid-conversion discards the result.
    @(negedge clk);
    min_in = 6'd12;
    sec_in = 6'd34;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset  = 1'b1;
    min_in = '0;
    sec_in = '0;
    @(negedge clk);
    checkOutput("t5_busy", int'(busy), 0);
    checkOutput("t5_digits", int'({min_tens, min_ones, sec_tens, sec_ones}), 0);
    checkOutput("t5_overrange", int'(overrange), 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // Random values including over-range, mixing explicit start and auto-start.
    pm = '0;
    ps = '0;
    for (int i = 0; i < 200; i++) begin
      rm = 6'($urandom_range(0, 63));
      rs = 6'($urandom_range(0, 63));
      us = 1'($urandom_range(0, 1));
      if (rm == pm && rs == ps) us = 1'b1;
      applyStimulus(rm, rs, us, lat, bc);
      checkOutput("rand_latency", lat, 7);
      pm = rm;
      ps = rs;
    end

    // Every legal minute/second pair.
    for (int m = 0; m < 60; m++) begin
      for (int s = 0; s < 60; s++) begin
        applyStimulus(6'(m), 6'(s), 1'b1, lat, bc);
      end
    end

    repeat (10) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
